ram_program_loader: RTL

//  Serial program loader sitting directly upstream of the 16-byte program/data RAM.

---
 rtl/ram_program_loader_if.sv | 29 ++
 rtl/ram_program_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ram_program_loader_if.sv
// Bus bundle between the CPU/serial-host side and the program loader.
// master drives CPU and serial inputs; slave is the loader producing the RAM port.
interface ram_program_loader_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          prog_en;
    logic          sck;
    logic          sdi;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_ri;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          ri;
    logic          halt;
    logic          load_done;
    logic [AW:0]   byte_cnt;

    modport master (
        output prog_en, sck, sdi, cpu_addr, cpu_din, cpu_ri,
        input  addr, din, ri, halt, load_done, byte_cnt
    );

    modport slave (
        input  prog_en, sck, sdi, cpu_addr, cpu_din, cpu_ri,
        output addr, din, ri, halt, load_done, byte_cnt
    );
endinterface

// File: rtl/ram_program_loader.sv
// Serial program loader: halts the CPU and fills RAM 0..DEPTH-1 from an MSB-first
// SCK/SDI stream while PROG_EN is high; otherwise passes CPU RAM signals through.
module ram_program_loader #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ram_program_loader_if.slave  bus
);
    localparam int BW = $clog2(DW + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WRITE, ST_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_prog_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sck_d;
    logic                   r_sck_rise;
    logic                   r_sdi_d;
    logic [BW-1:0]          r_bit_cnt;
    logic [AW-1:0]          r_addr;
    logic [DW-1:0]          r_shreg;
    logic [AW:0]            r_byte_cnt;
    logic                   w_prog_s;
    logic                   w_sck_s;
    logic                   w_sdi_s;
    logic                   w_last_bit;

    assign w_prog_s   = r_prog_sync[SYNC_STAGES-1];
    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
    assign w_last_bit = r_sck_rise && (r_bit_cnt == LAST_BIT);

    // The rise pulse is registered, so SDI gets one matching delay flop to stay aligned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prog_sync <= '0;
            r_sck_sync  <= '0;
            r_sdi_sync  <= '0;
            r_sck_d     <= 1'b0;
            r_sck_rise  <= 1'b0;
            r_sdi_d     <= 1'b0;
        end else begin
            r_prog_sync <= {r_prog_sync[SYNC_STAGES-2:0], bus.prog_en};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], bus.sdi};
            r_sck_d     <= w_sck_s;
            r_sck_rise  <= w_sck_s & ~r_sck_d;
            r_sdi_d     <= w_sdi_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A completed byte takes priority over an abort in the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_prog_s) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_bit)     w_state_next = ST_WRITE;
                else if (!w_prog_s) w_state_next = ST_IDLE;
            end
            ST_WRITE: begin
                if (r_addr == LAST_ADDR) w_state_next = ST_DONE;
                else                     w_state_next = ST_SHIFT;
            end
            ST_DONE: begin
                if (!w_prog_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt  <= '0;
            r_addr     <= '0;
            r_shreg    <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_prog_s) begin
                        r_bit_cnt  <= '0;
                        r_addr     <= '0;
                        r_shreg    <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (r_sck_rise) begin
                        r_shreg   <= {r_shreg[DW-2:0], r_sdi_d};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_bit_cnt <= '0;
                    // Address holds at the last location instead of wrapping.
                    if (r_addr != LAST_ADDR)   r_addr     <= r_addr + 1'b1;
                    if (r_byte_cnt != FULL_CNT) r_byte_cnt <= r_byte_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.addr      = bus.cpu_addr;
        bus.din       = bus.cpu_din;
        bus.ri        = bus.cpu_ri;
        bus.halt      = 1'b0;
        bus.load_done = 1'b0;
        bus.byte_cnt  = r_byte_cnt;
        case (r_state)
            ST_SHIFT: begin
                bus.addr = r_addr;
                bus.din  = r_shreg;
                bus.ri   = 1'b0;
                bus.halt = 1'b1;
            end
            ST_WRITE: begin
                bus.addr = r_addr;
                bus.din  = r_shreg;
                bus.ri   = 1'b1;
                bus.halt = 1'b1;
            end
            ST_DONE: bus.load_done = 1'b1;
            default: ;
        endcase
    end
endmodule
